// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified MIPS memory: CPU (0) and debug unit (1).
// Serialises accesses onto the single memory port; every output is registered.
module mem_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,  // legal range 1..4
  parameter int PRIO_MODE = 0   // 0 = round-robin, 1 = debug always wins
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  // Handshake: a requester raises req (level) with stable we/addr/wdata and
  // holds it until its ack pulses for one cycle; req must be low in the cycle
  // after ack. Only the values present in the granting IDLE cycle are used.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t        state, state_d;
  logic [2:0]    cnt, cnt_d;
  logic          lat_we, we_d;
  logic          owner_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          grant_dbg;
  logic          mem_en_d, mem_we_d, busy_d, cpu_ack_d, dbg_ack_d;

  always_comb begin
    if (cpu_req && dbg_req) grant_dbg = (PRIO_MODE == 1) ? 1'b1 : ~owner;
    else                    grant_dbg = dbg_req;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = lat_we;
    owner_d = owner;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = rdata_q;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = grant_dbg;
          we_d    = grant_dbg ? dbg_we    : cpu_we;
          addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt - 3'd1;
        // Counter reaching 1 marks the cycle the memory presents read data.
        if (cnt == 3'd1) begin
          state_d = DONE;
          if (!lat_we) rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_comb begin
    mem_en_d  = (state_d == ISSUE);
    mem_we_d  = (state_d == ISSUE) && we_d;
    busy_d    = (state_d != IDLE);
    cpu_ack_d = (state_d == DONE) && !owner_d;
    dbg_ack_d = (state_d == DONE) && owner_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      lat_we    <= 1'b0;
      owner     <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      lat_we    <= we_d;
      owner     <= owner_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rdata_q   <= rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
      cpu_ack   <= cpu_ack_d;
      dbg_ack   <= dbg_ack_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RR lat 1, fixed-prio lat 1, RR lat 3),
// each with its own latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int RND_CYCLES = 800;

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic int pri_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [DW-1:0] init_word(input int unsigned s, input int a);
    if (s == 0 && a == 'h10) return 32'hDEADBEEF;
    if (s == 0 && a == 'h05) return 32'hA5A5A5A5;
    return {8'(a), 8'(s), ~8'(a), 8'(a * 7 + int'(s))};
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req[N], cpu_we[N], dbg_req[N], dbg_we[N];
  logic [AW-1:0] cpu_addr[N], dbg_addr[N], mem_addr[N];
  logic [DW-1:0] cpu_wdata[N], dbg_wdata[N], mem_wdata[N], mem_rdata[N];
  logic [DW-1:0] cpu_rdata[N], dbg_rdata[N];
  logic          cpu_ack[N], dbg_ack[N], mem_en[N], mem_we[N], busy[N], owner[N];
  logic          load;
  int unsigned   seed;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int L = lat_of(g);
    logic [DW-1:0] mem [256];
    logic [DW-1:0] pipe [L];

    // Data appears L cycles after mem_en; filler otherwise so late/early capture shows.
    always @(posedge clk) begin
      if (load) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(seed, i);
      end else if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
      end
      pipe[0] <= mem_en[g] ? mem[mem_addr[g]] : 32'h0BAD0BAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L), .PRIO_MODE(pri_of(g))) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_ack(dbg_ack[g]), .dbg_rdata(dbg_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .owner(owner[g])
    );
  end

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input bit r, input logic q, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (r) begin
      dbg_req[k] = q; dbg_we[k] = w; dbg_addr[k] = a; dbg_wdata[k] = d;
    end else begin
      cpu_req[k] = q; cpu_we[k] = w; cpu_addr[k] = a; cpu_wdata[k] = d;
    end
  endtask

  // Leaves the bench at the negedge of the first post-reset cycle (cycle 0).
  task automatic reset_all(input int unsigned s);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(k, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    seed = s;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    int            k;
    bit            r;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ack;
  } vec_t;
  vec_t vt[6];

  // ---------------- reference model state (random phase) ----------------
  int            free_at[N], grant_at[N], ack_at[N];
  bit            pend[N], win[N], t_we[N], last[N];
  logic [DW-1:0] exp_rd[N], rd_reg[N];
  logic [DW-1:0] ref_mem[N][256];
  bit            outst[N][2];
  int            gap[N][2];
  bit            ea_c, ea_d, ack_seen, rq_c, rq_d, w;
  logic          tw;
  logic [AW-1:0] ta;
  logic [DW-1:0] td;
  int            n_c0, n_d0, n_d1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    seed = 0;

    vt[0] = '{0, 1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 3};
    vt[1] = '{2, 1'b1, 1'b0, 8'h05, 32'h0,        32'hA5A5A5A5, 5};
    vt[2] = '{1, 1'b0, 1'b0, 8'h05, 32'h0,        32'hA5A5A5A5, 3};
    vt[3] = '{0, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 32'h0,        3};
    vt[4] = '{2, 1'b0, 1'b1, 8'h10, 32'h13579BDF, 32'h0,        5};
    vt[5] = '{1, 1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 3};

    // Reset values, sampled while reset is still asserted.
    reset_all(0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst cpu_ack i%0d", k), cpu_ack[k], 0);
      chk($sformatf("rst dbg_ack i%0d", k), dbg_ack[k], 0);
      chk($sformatf("rst mem_en i%0d", k), mem_en[k], 0);
      chk($sformatf("rst mem_we i%0d", k), mem_we[k], 0);
      chk($sformatf("rst busy i%0d", k), busy[k], 0);
      chk($sformatf("rst owner i%0d", k), owner[k], 1);
      chk($sformatf("rst mem_addr i%0d", k), mem_addr[k], 0);
      chk($sformatf("rst mem_wdata i%0d", k), mem_wdata[k], 0);
      chk($sformatf("rst cpu_rdata i%0d", k), cpu_rdata[k], 0);
      chk($sformatf("rst dbg_rdata i%0d", k), dbg_rdata[k], 0);
    end

    // Single transactions from the table.
    for (int i = 0; i < 6; i++) begin
      reset_all(0);
      drive(vt[i].k, vt[i].r, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
      for (int c = 0; c <= vt[i].ack + 1; c++) begin
        chk($sformatf("v%0d cpu_ack c%0d", i, c), cpu_ack[vt[i].k], (c == vt[i].ack) && !vt[i].r);
        chk($sformatf("v%0d dbg_ack c%0d", i, c), dbg_ack[vt[i].k], (c == vt[i].ack) && vt[i].r);
        chk($sformatf("v%0d mem_en c%0d", i, c), mem_en[vt[i].k], c == 1);
        chk($sformatf("v%0d mem_we c%0d", i, c), mem_we[vt[i].k], (c == 1) && vt[i].we);
        chk($sformatf("v%0d busy c%0d", i, c), busy[vt[i].k], (c >= 1) && (c <= vt[i].ack));
        if (c == 1) begin
          chk($sformatf("v%0d mem_addr", i), mem_addr[vt[i].k], vt[i].addr);
          if (vt[i].we) chk($sformatf("v%0d mem_wdata", i), mem_wdata[vt[i].k], vt[i].wdata);
        end
        if (c == vt[i].ack) begin
          chk($sformatf("v%0d cpu_rdata", i), cpu_rdata[vt[i].k], vt[i].rdata);
          chk($sformatf("v%0d dbg_rdata", i), dbg_rdata[vt[i].k], vt[i].rdata);
          chk($sformatf("v%0d owner", i), owner[vt[i].k], vt[i].r);
          drive(vt[i].k, vt[i].r, 1'b0, 1'b0, '0, '0);
        end
        @(negedge clk);
      end
    end

    // Simultaneous requests: CPU read, debug write, then CPU reads it back.
    reset_all(0);
    drive(0, 1'b0, 1'b1, 1'b0, 8'h00, '0);
    drive(0, 1'b1, 1'b1, 1'b1, 8'h20, 32'h12345678);
    for (int c = 0; c <= 12; c++) begin
      chk($sformatf("t2 cpu_ack c%0d", c), cpu_ack[0], (c == 3) || (c == 11));
      chk($sformatf("t2 dbg_ack c%0d", c), dbg_ack[0], c == 7);
      chk($sformatf("t2 mem_en c%0d", c), mem_en[0], (c == 1) || (c == 5) || (c == 9));
      if (c == 3) begin
        chk("t2 first rdata", cpu_rdata[0], init_word(0, 0));
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (c == 4) chk("t2 owner cpu", owner[0], 0);
      if (c == 5) begin
        chk("t2 write mem_we", mem_we[0], 1);
        chk("t2 write addr", mem_addr[0], 8'h20);
        chk("t2 write data", mem_wdata[0], 32'h12345678);
        chk("t2 owner dbg", owner[0], 1);
      end
      if (c == 7) begin
        drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b0, 1'b1, 1'b0, 8'h20, '0);
      end
      if (c == 11) begin
        chk("t2 readback", cpu_rdata[0], 32'h12345678);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
    end

    // Both requests held high: alternation (inst 0) and debug priority (inst 1).
    reset_all(0);
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 1'b1, 1'b0, 8'h01, '0);
      drive(k, 1'b1, 1'b1, 1'b0, 8'h02, '0);
    end
    n_c0 = 0; n_d0 = 0; n_d1 = 0;
    for (int c = 0; c <= 16; c++) begin
      chk($sformatf("rr cpu_ack c%0d", c), cpu_ack[0], (c == 3) || (c == 11));
      chk($sformatf("rr dbg_ack c%0d", c), dbg_ack[0], (c == 7) || (c == 15));
      chk($sformatf("fp dbg_ack c%0d", c), dbg_ack[1], (c % 4 == 3));
      chk($sformatf("fp cpu_ack c%0d", c), cpu_ack[1], 0);
      chk($sformatf("fp owner c%0d", c), owner[1], 1);
      n_c0 += int'(cpu_ack[0]);
      n_d0 += int'(dbg_ack[0]);
      n_d1 += int'(dbg_ack[1]);
      @(negedge clk);
    end
    chk("rr total acks", n_c0 + n_d0, 4);
    chk("fp total acks", n_d1, 4);

    // Reset mid-WAIT on the latency-3 instance, then restart.
    reset_all(0);
    drive(2, 1'b0, 1'b1, 1'b0, 8'h05, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t5 busy in wait", busy[2], 1);
    #2 rst = 1'b0;
    #1;
    chk("t5 async busy", busy[2], 0);
    chk("t5 async mem_en", mem_en[2], 0);
    chk("t5 async owner", owner[2], 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5 no ack in reset %0d", c), cpu_ack[2], 0);
    end
    rst = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      chk($sformatf("t5 cpu_ack c%0d", c), cpu_ack[2], c == 5);
      chk($sformatf("t5 mem_en c%0d", c), mem_en[2], c == 1);
      if (c == 5) begin
        chk("t5 rdata", cpu_rdata[2], 32'hA5A5A5A5);
        drive(2, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
    end

    // Randomized traffic on all instances against the transaction-level model.
    reset_all(1 + $urandom_range(0, 1000));
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(seed, a);
      free_at[k] = 0; pend[k] = 0; last[k] = 1; rd_reg[k] = '0;
      for (int r = 0; r < 2; r++) begin
        outst[k][r] = 0;
        gap[k][r]   = $urandom_range(0, 3);
      end
    end
    for (int c = 0; c < RND_CYCLES; c++) begin
      for (int k = 0; k < N; k++) begin
        ea_c = pend[k] && (ack_at[k] == c) && !win[k];
        ea_d = pend[k] && (ack_at[k] == c) && win[k];
        chk($sformatf("rnd i%0d cpu_ack c%0d", k, c), cpu_ack[k], ea_c);
        chk($sformatf("rnd i%0d dbg_ack c%0d", k, c), dbg_ack[k], ea_d);
        chk($sformatf("rnd i%0d busy c%0d", k, c), busy[k],
            pend[k] && (c > grant_at[k]) && (c <= ack_at[k]));
        if (ea_c || ea_d) begin
          if (!t_we[k]) rd_reg[k] = exp_rd[k];
          chk($sformatf("rnd i%0d cpu_rdata c%0d", k, c), cpu_rdata[k], rd_reg[k]);
          chk($sformatf("rnd i%0d dbg_rdata c%0d", k, c), dbg_rdata[k], rd_reg[k]);
          chk($sformatf("rnd i%0d owner c%0d", k, c), owner[k], win[k]);
          pend[k] = 0;
        end
        for (int r = 0; r < 2; r++) begin
          ack_seen = r ? dbg_ack[k] : cpu_ack[k];
          if (outst[k][r]) begin
            if (ack_seen) begin
              outst[k][r] = 0;
              gap[k][r]   = $urandom_range(0, 3);
              drive(k, r[0], 1'b0, 1'b0, '0, '0);
            end else if (pend[k] && (win[k] == r[0]) && ($urandom_range(0, 3) == 0)) begin
              tw = r ? dbg_we[k] : cpu_we[k];
              drive(k, r[0], 1'($urandom_range(0, 1)), tw, AW'($urandom_range(0, 15)), $urandom);
            end
          end else if (gap[k][r] == 0) begin
            outst[k][r] = 1;
            drive(k, r[0], 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
          end else begin
            gap[k][r]--;
          end
        end
        rq_c = cpu_req[k];
        rq_d = dbg_req[k];
        if (!pend[k] && (c >= free_at[k]) && (rq_c || rq_d)) begin
          if (rq_c && rq_d) w = (pri_of(k) == 1) ? 1'b1 : !last[k];
          else              w = rq_d;
          tw = w ? dbg_we[k]    : cpu_we[k];
          ta = w ? dbg_addr[k]  : cpu_addr[k];
          td = w ? dbg_wdata[k] : cpu_wdata[k];
          pend[k]     = 1;
          win[k]      = w;
          last[k]     = w;
          t_we[k]     = tw;
          grant_at[k] = c;
          ack_at[k]   = c + lat_of(k) + 2;
          free_at[k]  = c + lat_of(k) + 3;
          if (tw) ref_mem[k][ta] = td;
          else    exp_rd[k] = ref_mem[k][ta];
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle MIPS CPU between two requesters: the CPU control/datapath (requester 0) and the debug unit (requester 1).
- Each requester uses a req/ack handshake. The block serialises accesses, drives the one memory port and returns read data.
- Sits between the control unit, the debug unit and the memory. The CPU control FSM stalls in its memory states until `cpu_ack`.

Parameters:
- `AW`, 8, word-address width.
- `DW`, 32, data width.
- `MEM_LAT`, 1, memory read latency in cycles from `mem_en` to valid `mem_rdata`. Legal range 1..4.
- `PRIO_MODE`, 0. 0 = round-robin; 1 = fixed priority, debug wins.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU access request; level, held until `cpu_ack`.
- `cpu_we` in 1: CPU write enable; stable while `cpu_req` is high.
- `cpu_addr` in AW: CPU word address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `cpu_rdata` out DW: read data; valid in the `cpu_ack` cycle.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same as the CPU group, for the debug unit.
- `mem_en` out 1: memory access strobe, one cycle per transaction.
- `mem_we` out 1: memory write strobe; only high together with `mem_en`.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: current/last grant (0 = CPU, 1 = debug).

Behaviour:
- All outputs are registered.
- Reset values:
  - `cpu_ack`, `dbg_ack`, `mem_en`, `mem_we`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dbg_rdata` = 0.
  - `owner` = 1, so the CPU wins the first round-robin tie.
  - FSM = IDLE; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select the winner, latch its `we`/`addr`/`wdata` into internal registers, set `owner`, go to ISSUE.
- Arbitration:
  - Only one request: it wins.
  - Both requests, `PRIO_MODE`=0: winner is the requester other than `owner`.
  - Both requests, `PRIO_MODE`=1: debug wins.
- ISSUE (exactly 1 cycle):
  - `mem_en`=1; `mem_we` = latched `we`; `mem_addr`/`mem_wdata` driven from the latched copy.
  - Load counter = `MEM_LAT`; go to WAIT.
- WAIT:
  - `mem_en`=0, `mem_we`=0; decrement the counter each cycle.
  - In the cycle where the counter = 1: for reads, capture `mem_rdata` into the shared read-data register (drives both `cpu_rdata` and `dbg_rdata`); go to DONE.
  - For writes, the read-data register is unchanged.
- DONE (exactly 1 cycle):
  - Pulse `owner`'s ack (`cpu_ack` or `dbg_ack`) for one cycle; the other ack stays 0.
  - Go to IDLE. No re-arbitration in DONE; minimum one IDLE cycle between transactions.
- Latency: with `req` first high in IDLE cycle 0, `mem_en` is high in cycle 1 and ack in cycle `MEM_LAT`+2.
- Throughput, back-to-back: one transaction per `MEM_LAT`+3 cycles.
- Requester obligations:
  - Deassert `req` in the cycle after ack; a `req` still high in IDLE is treated as a new request.
  - `req` dropped mid-transaction is ignored: the transaction completes and ack still pulses.
  - Address/data changes after grant are ignored (latched copy is used).
- Write-read ordering: a read issued after a write to the same address returns the new data, since accesses are strictly serialised.
- Reset low in any state (asynchronous):
  - All outputs go to reset values immediately; `mem_en`/`mem_we` drop in the same cycle.
  - The aborted transaction gets no ack.
  - After reset is released, pending requests re-arbitrate from IDLE with `owner`=1.
- Counter width: 3 bits; no wrap-around, since `MEM_LAT` ≤ 4.

Test Plan:
1. `MEM_LAT`=1; preload mem[0x10]=0xDEADBEEF; `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x10 at cycle 0 → `mem_en`=1 with `mem_addr`=0x10 in cycle 1; `cpu_ack`=1 and `cpu_rdata`=0xDEADBEEF in cycle 3; `dbg_ack` stays 0.
2. After reset, both request in cycle 0: CPU reads 0x00; debug writes 0x12345678 to 0x20 → CPU acked in cycle 3. `mem_en`+`mem_we`=1 with `mem_addr`=0x20 and `mem_wdata`=0x12345678 in cycle 5; `dbg_ack` in cycle 7. A following CPU read of 0x20 returns 0x12345678.
3. `PRIO_MODE`=0; both `req` held high for 16 cycles, re-asserted after each ack → grants alternate C,D,C,D; exactly 4 acks, in cycles 3,7,11,15.
4. `PRIO_MODE`=1; both `req` held high → only `dbg_ack` pulses (cycles 3,7,11,15); `cpu_ack` stays 0; `owner`=1 throughout.
5. `rst` driven low mid-WAIT (cycle 2, `MEM_LAT`=3) → `busy`, `mem_en`=0 asynchronously; no ack. After release with `cpu_req` still high, the CPU transaction restarts: ack `MEM_LAT`+2 cycles after the first IDLE cycle.
6. `MEM_LAT`=3, debug read of 0x05 (mem=0xA5A5A5A5) → `mem_en` in cycle 1 only; `dbg_ack` and `dbg_rdata`=0xA5A5A5A5 in cycle 5; `busy` high in cycles 1–5.
